c_unloader: RTL and testbench

C_UNLOADER -- requirements
Module: c_unloader

---
 rtl/c_unloader.sv | 157 +++++++++++++++
 tb/tb_c_unloader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/c_unloader.sv
// c_unloader: drains the C matrix out of a DIM x DIM systolic array one row at
// a time and offers each row downstream on a valid/ready handshake.
//
// Optional feature macro: C_CLEAR_EN
//   defined   -> after each row is accepted downstream the row is written back
//                as zero (CLEAR state), leaving C ready for the next accumulation.
//   undefined -> no CLEAR state, WrEn tied low, C left untouched by a drain.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle drain request (honoured only in IDLE)
//   busy, done         busy outside IDLE; done pulses one cycle after last row
//   Crow, Cout         row select to / row data from the systolic array
//   WrEn, Cin          row write strobe / write data (always zero) to the array
//   out_valid/ready    downstream handshake
//   out_data, out_row  captured row and its index

// Per-lane capture register: one C element of the row word.
module c_unloader_lane #(
  parameter int BITS_C = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_i,
  input  logic [BITS_C-1:0] d_i,
  output logic [BITS_C-1:0] q_o
);
  logic [BITS_C-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q_q <= '0;
    else if (cap_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module c_unloader #(
  parameter  int BITS_C = 16,
  parameter  int DIM    = 8,
  localparam int RW     = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic [RW-1:0]                       Crow,
  input  logic signed [DIM-1:0][BITS_C-1:0]   Cout,
  output logic                                WrEn,
  output logic signed [DIM-1:0][BITS_C-1:0]   Cin,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [DIM-1:0][BITS_C-1:0]   out_data,
  output logic [RW-1:0]                       out_row
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    SEND,
`ifdef C_CLEAR_EN
    CLEAR,
`endif
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   out_row_q;
  logic            cap;
  logic            last_row;

  assign last_row = (cnt_q == RW'(DIM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_row_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) out_row_q <= cnt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        cnt_d   = '0;
        state_d = ADDR;
      end
      // Crow is presented for this single cycle; Cout is captured on its
      // closing edge.
      ADDR: begin
        cap     = 1'b1;
        state_d = SEND;
      end
      SEND: if (out_ready) begin
`ifdef C_CLEAR_EN
        state_d = CLEAR;
`else
        // Stop at the last row rather than wrapping the counter.
        if (last_row) state_d = DONE;
        else begin
          cnt_d   = cnt_q + RW'(1);
          state_d = ADDR;
        end
`endif
      end
`ifdef C_CLEAR_EN
      CLEAR: begin
        if (last_row) state_d = DONE;
        else begin
          cnt_d   = cnt_q + RW'(1);
          state_d = ADDR;
        end
      end
`endif
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row capture, one register per lane.
  for (genvar l = 0; l < DIM; l++) begin : g_lane
    c_unloader_lane #(.BITS_C(BITS_C)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .cap_i (cap),
      .d_i   (Cout[l]),
      .q_o   (out_data[l])
    );
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == SEND);
  assign out_row   = out_row_q;
  // Row select parks at 0 when idle; it stays on the current row through
  // SEND so a downstream stall never moves it.
  assign Crow      = (state_q == IDLE || state_q == DONE) ? '0 : cnt_q;
  assign Cin       = '0;
`ifdef C_CLEAR_EN
  assign WrEn      = (state_q == CLEAR);
`else
  assign WrEn      = 1'b0;
`endif

endmodule

// File: tb/tb_c_unloader.sv
module tb_c_unloader;
  localparam int BITS_C = 16;
  localparam int DIM    = 8;
  localparam int RW     = $clog2(DIM);
`ifdef C_CLEAR_EN
  localparam int LAT   = 3*DIM + 1;
  localparam int WREXP = DIM;
  localparam bit CLR   = 1'b1;
`else
  localparam int LAT   = 2*DIM + 1;
  localparam int WREXP = 0;
  localparam bit CLR   = 1'b0;
`endif

  typedef logic [DIM-1:0][BITS_C-1:0] row_t;
  typedef struct { logic [RW-1:0] row; row_t data; } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, out_ready, busy, done, WrEn, out_valid;
  logic [RW-1:0] Crow, out_row;
  logic signed [DIM-1:0][BITS_C-1:0] Cout, Cin, out_data;

  row_t cmem [DIM];
  exp_t q[$];
  exp_t e;
  int   total = 0, bad = 0;
  int   words = 0, dones = 0, wrens = 0;
  int   pat = 0;
  bit   cleared = 1'b0;
  logic load_req = 1'b0;

  always #5 clk = ~clk;

  c_unloader #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .Crow(Crow), .Cout(Cout), .WrEn(WrEn), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row)
  );

  function automatic logic [BITS_C-1:0] pat_val(input int p, input int r, input int c);
    if (p == 0) return BITS_C'(r*8 + c);
    return BITS_C'(-(r + 1));
  endfunction

  function automatic row_t exp_row(input int r);
    row_t v;
    for (int c = 0; c < DIM; c++) v[c] = cleared ? '0 : pat_val(pat, r, c);
    return v;
  endfunction

  // Systolic-array C storage model.
  always @(posedge clk) begin
    if (load_req) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) cmem[r][c] <= pat_val(pat, r, c);
    end else if (WrEn) cmem[Crow] <= Cin;
  end
  assign Cout = cmem[Crow];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: inputs only change just after posedge, so negedge sees what the
  // next edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        chk("sb_has_entry", 128'(q.size() > 0), 128'(1));
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("out_row", 128'(out_row), 128'(e.row));
          chk("out_data", 128'(out_data), 128'(e.data));
          words++;
        end
      end
      if (done) dones++;
      if (WrEn) wrens++;
      chk("crow_range", 128'(Crow < RW'(DIM-1) || Crow == RW'(DIM-1)), 128'(1));
      chk("cin_zero", 128'(Cin), 128'(0));
    end
  end

  task automatic load(input int p);
    pat = p; cleared = 1'b0; load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic push_all();
    exp_t x;
    for (int r = 0; r < DIM; r++) begin
      x.row = RW'(r); x.data = exp_row(r); q.push_back(x);
    end
  endtask

  task automatic run_drain(input int stall_row, input bit restart);
    int n; bit seen; bit stalled;
    push_all();
    words = 0; dones = 0; wrens = 0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    n = 1; seen = 1'b0; stalled = 1'b0;
    while (n < 400 && !seen) begin
      if (done) seen = 1'b1;
      else begin
        start = (restart && n == 4);
        if (stall_row >= 0 && !stalled && out_valid && out_row == RW'(stall_row)) begin
          stalled = 1'b1; out_ready = 1'b0;
          repeat (5) begin
            @(posedge clk); #1; n++;
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_row", 128'(out_row), 128'(stall_row));
            chk("stall_crow", 128'(Crow), 128'(stall_row));
            chk("stall_data", 128'(out_data), 128'(exp_row(stall_row)));
          end
          out_ready = 1'b1;
        end
        @(posedge clk); #1; n++;
      end
    end
    start = 1'b0;
    chk("done_seen", 128'(seen), 128'(1));
    if (stall_row < 0) chk("latency", 128'(n), 128'(LAT));
    if (restart) start = 1'b1;  // sampled while in DONE
    @(posedge clk); #1; start = 1'b0;
    chk("idle_after_done", 128'(busy), 128'(0));
    repeat (3) begin @(posedge clk); #1; end
    chk("stay_idle", 128'(busy), 128'(0));
    chk("word_count", 128'(words), 128'(DIM));
    chk("done_count", 128'(dones), 128'(1));
    chk("wren_count", 128'(wrens), 128'(WREXP));
    chk("sb_drained", 128'(q.size()), 128'(0));
    if (CLR) cleared = 1'b1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"},      128'(busy),      128'(0));
    chk({pfx, "_done"},      128'(done),      128'(0));
    chk({pfx, "_crow"},      128'(Crow),      128'(0));
    chk({pfx, "_wren"},      128'(WrEn),      128'(0));
    chk({pfx, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({pfx, "_out_data"},  128'(out_data),  128'(0));
    chk({pfx, "_out_row"},   128'(out_row),   128'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Ascending pattern, ready tied high.
    load(0);
    run_drain(-1, 1'b0);

    // Second drain with a 5-cycle stall on row 3 (zeros if rows were cleared).
    run_drain(3, 1'b0);

    // Negative values keep their sign.
    load(1);
    run_drain(-1, 1'b0);

    // Reset while row 2 is waiting in SEND.
    load(0);
    push_all();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (n < 100 && !(out_valid && out_row == RW'(2))) begin
      @(posedge clk); #1; n++;
    end
    chk("reach_row2", 128'(out_valid && out_row == RW'(2)), 128'(1));
    out_ready = 1'b0;
    rst_n = 1'b0; #1;
    chk_reset_vals("midrst");
    q.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    words = 0; dones = 0; wrens = 0;
    repeat (10) begin @(posedge clk); #1; end
    chk("post_rst_busy",  128'(busy),  128'(0));
    chk("post_rst_words", 128'(words), 128'(0));
    chk("post_rst_dones", 128'(dones), 128'(0));
    chk("post_rst_wrens", 128'(wrens), 128'(0));

    // Fresh start after reset, with start re-pulsed while busy and in DONE.
    load(0);
    run_drain(-1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
